// File: rtl/exe_stage_pkg.sv
// rtl/exe_stage_pkg.sv - bus widths, decode bus layout, divider states and store helpers
package exe_stage_pkg;

    localparam int DS_TO_ES_BUS_WD   = 161;
    localparam int ES_TO_MS_BUS_WD   = 76;
    localparam int ES_FWD_BLK_BUS_WD = 39;
    localparam int ES_MUL_RES_BUS_WD = 65;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    // Decode-to-execute bus, MSB first
    typedef struct packed {
        logic [11:0] alu_op;
        logic [3:0]  div_op;     // {div.w, mod.w, div.wu, mod.wu}
        logic [2:0]  mul_op;     // {mul.w, mulh.w, mulh.wu}
        logic [4:0]  load_op;    // {ld.b, ld.h, ld.w, ld.bu, ld.hu}
        logic [2:0]  store_op;   // {st.b, st.h, st.w}
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rkd_value;
        logic [31:0] pc;
    } ds_to_es_t;

    // Byte lanes written by a store at the given low address bits
    function automatic logic [3:0] store_be(input logic [2:0] store_op,
                                            input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        if (store_op[2]) begin
            be = 4'b0001 << addr_lo;
        end else if (store_op[1]) begin
            be = 4'b0011 << {addr_lo[1], 1'b0};
        end else if (store_op[0]) begin
            be = 4'b1111;
        end
        return be;
    endfunction

    // Store data replicated across every lane so the byte enables pick the right one
    function automatic logic [31:0] store_wdata(input logic [2:0]  store_op,
                                                input logic [31:0] rkd);
        logic [31:0] wd;
        wd = rkd;
        if (store_op[2]) begin
            wd = {4{rkd[7:0]}};
        end else if (store_op[1]) begin
            wd = {2{rkd[15:0]}};
        end
        return wd;
    endfunction

endpackage

// File: rtl/exe_stage_alu.sv
// rtl/exe_stage_alu.sv - combinational integer ALU used by the execute stage
module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    logic op_add, op_sub, op_slt, op_sltu, op_and, op_nor;
    logic op_or, op_xor, op_sll, op_srl, op_sra, op_lui;

    assign op_add  = alu_op[0];
    assign op_sub  = alu_op[1];
    assign op_slt  = alu_op[2];
    assign op_sltu = alu_op[3];
    assign op_and  = alu_op[4];
    assign op_nor  = alu_op[5];
    assign op_or   = alu_op[6];
    assign op_xor  = alu_op[7];
    assign op_sll  = alu_op[8];
    assign op_srl  = alu_op[9];
    assign op_sra  = alu_op[10];
    assign op_lui  = alu_op[11];

    // One shared adder: compares are computed as src1 - src2
    logic        adder_cin;
    logic [31:0] adder_b;
    logic [32:0] adder_sum;
    assign adder_cin = op_sub | op_slt | op_sltu;
    assign adder_b   = adder_cin ? ~alu_src2 : alu_src2;
    assign adder_sum = {1'b0, alu_src1} + {1'b0, adder_b} + {32'd0, adder_cin};

    logic        slt_res, sltu_res;
    logic [31:0] sll_res, srl_res, sra_res;
    assign slt_res  = (alu_src1[31] & ~alu_src2[31])
                    | (~(alu_src1[31] ^ alu_src2[31]) & adder_sum[31]);
    assign sltu_res = ~adder_sum[32];
    assign sll_res  = alu_src1 << alu_src2[4:0];
    assign srl_res  = alu_src1 >> alu_src2[4:0];
    assign sra_res  = $signed(alu_src1) >>> alu_src2[4:0];

    assign alu_result = ({32{op_add | op_sub}} & adder_sum[31:0])
                      | ({32{op_slt}}          & {31'd0, slt_res})
                      | ({32{op_sltu}}         & {31'd0, sltu_res})
                      | ({32{op_and}}          & (alu_src1 & alu_src2))
                      | ({32{op_nor}}          & ~(alu_src1 | alu_src2))
                      | ({32{op_or}}           & (alu_src1 | alu_src2))
                      | ({32{op_xor}}          & (alu_src1 ^ alu_src2))
                      | ({32{op_sll}}          & sll_res)
                      | ({32{op_srl}}          & srl_res)
                      | ({32{op_sra}}          & sra_res)
                      | ({32{op_lui}}          & alu_src2);

endmodule

// File: rtl/exe_stage_divider.sv
// rtl/exe_stage_divider.sv - 32-cycle restoring divider with signed correction
module divider
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        done,
    input  logic        ack,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;      // dividend magnitude; quotient bits shift in at the LSB
    logic [31:0] dvs_q, dvs_d;      // divisor magnitude
    logic [31:0] rem_q, rem_d;      // partial remainder magnitude
    logic        x_neg_q, x_neg_d;  // signed op with negative dividend
    logic        y_neg_q, y_neg_d;  // signed op with negative divisor

    logic [32:0] trial;
    logic        no_borrow;

    // Shift the next dividend bit into the remainder and try the subtraction
    assign trial     = {rem_q, dvd_q[31]};
    assign no_borrow = trial >= {1'b0, dvs_q};

    // Next-state: latch magnitudes on start, one restoring step per BUSY cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        x_neg_d = x_neg_q;
        y_neg_d = y_neg_q;
        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    state_d = DIV_BUSY;
                    cnt_d   = 5'd0;
                    x_neg_d = signed_op & x[31];
                    y_neg_d = signed_op & y[31];
                    dvd_d   = (signed_op & x[31]) ? -x : x;
                    dvs_d   = (signed_op & y[31]) ? -y : y;
                    rem_d   = 32'd0;
                end
            end
            DIV_BUSY: begin
                rem_d = no_borrow ? (trial[31:0] - dvs_q) : trial[31:0];
                dvd_d = {dvd_q[30:0], no_borrow};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (ack) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any division in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= 5'd0;
            dvd_q   <= 32'd0;
            dvs_q   <= 32'd0;
            rem_q   <= 32'd0;
            x_neg_q <= 1'b0;
            y_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            x_neg_q <= x_neg_d;
            y_neg_q <= y_neg_d;
        end
    end

    assign done      = (state_q == DIV_DONE);
    assign quotient  = (x_neg_q ^ y_neg_q) ? -dvd_q : dvd_q;
    assign remainder = x_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ALU, multiply, iterative divide, data SRAM request
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         ms_allowin,
    output logic                         es_allowin,
    input  logic                         ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0]   ds_to_es_bus,
    output logic                         es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
    output logic [ES_MUL_RES_BUS_WD-1:0] es_mul_res_bus,
    output logic                         data_sram_en,
    output logic [3:0]                   data_sram_we,
    output logic [31:0]                  data_sram_addr,
    output logic [31:0]                  data_sram_wdata,
    output logic [ES_FWD_BLK_BUS_WD-1:0] es_fwd_blk_bus
);
    logic                         es_valid_q, es_valid_d;
    ds_to_es_t                    es_bus_q, es_bus_d;
    logic [ES_MUL_RES_BUS_WD-1:0] mul_res_q, mul_res_d;

    logic        is_div, div_done, es_ready_go, es_xfer;
    logic        is_load, is_store, is_mul, res_from_mul, blk;
    logic [31:0] alu_result, div_quotient, div_remainder, div_result, es_result;

    assign is_div   = |es_bus_q.div_op;
    assign is_load  = |es_bus_q.load_op;
    assign is_store = |es_bus_q.store_op;
    assign is_mul   = |es_bus_q.mul_op;

    // Stage handshake: only an unfinished division holds the instruction here
    assign es_ready_go    = !is_div | div_done;
    assign es_allowin     = !es_valid_q | (es_ready_go & ms_allowin);
    assign es_to_ms_valid = es_valid_q & es_ready_go;
    assign es_xfer        = es_to_ms_valid & ms_allowin;

    alu u_alu (
        .alu_op     (es_bus_q.alu_op),
        .alu_src1   (es_bus_q.src1),
        .alu_src2   (es_bus_q.src2),
        .alu_result (alu_result)
    );

    divider u_divider (
        .clk       (clk),
        .resetn    (resetn),
        .start     (es_valid_q & is_div),
        .signed_op (es_bus_q.div_op[3] | es_bus_q.div_op[2]),
        .x         (es_bus_q.src1),
        .y         (es_bus_q.src2),
        .done      (div_done),
        .ack       (es_xfer),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    // div.w/div.wu return the quotient, mod.w/mod.wu the remainder
    assign div_result = (es_bus_q.div_op[3] | es_bus_q.div_op[1]) ? div_quotient : div_remainder;
    assign es_result  = is_div ? div_result : alu_result;

    // Multiply on 33-bit operands so one signed multiplier covers both signednesses
    logic        mul_signed, mulh_sel;
    logic [32:0] mul_a, mul_b;
    logic [63:0] mul_prod;
    assign mul_signed = es_bus_q.mul_op[2] | es_bus_q.mul_op[1];
    assign mulh_sel   = es_bus_q.mul_op[1] | es_bus_q.mul_op[0];
    assign mul_a      = {mul_signed & es_bus_q.src1[31], es_bus_q.src1};
    assign mul_b      = {mul_signed & es_bus_q.src2[31], es_bus_q.src2};
    assign mul_prod   = 64'($signed(mul_a) * $signed(mul_b));
    assign res_from_mul = is_mul;

    // Next-state for the pipeline valid, the instruction bus and the product register
    always_comb begin
        es_valid_d = es_valid_q;
        es_bus_d   = es_bus_q;
        mul_res_d  = mul_res_q;
        if (es_allowin) begin
            es_valid_d = ds_to_es_valid;
        end
        if (ds_to_es_valid & es_allowin) begin
            es_bus_d = ds_to_es_bus;
        end
        if (es_xfer) begin
            mul_res_d = {mulh_sel, mul_prod};
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid_q <= 1'b0;
            es_bus_q   <= '0;
            mul_res_q  <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            es_bus_q   <= es_bus_d;
            mul_res_q  <= mul_res_d;
        end
    end

    // The SRAM request goes out on the cycle the memory op moves on to mem_stage
    assign data_sram_en    = es_valid_q & ms_allowin & (is_load | is_store);
    assign data_sram_addr  = alu_result;
    assign data_sram_we    = data_sram_en ? store_be(es_bus_q.store_op, alu_result[1:0]) : 4'b0000;
    assign data_sram_wdata = store_wdata(es_bus_q.store_op, es_bus_q.rkd_value);

    // Loads, multiplies and unfinished divides cannot forward their value yet
    assign blk = es_valid_q & (is_load | is_mul | (is_div & !div_done));

    assign es_to_ms_bus   = {res_from_mul, es_bus_q.load_op, es_bus_q.gr_we,
                             es_bus_q.dest, es_result, es_bus_q.pc};
    assign es_mul_res_bus = mul_res_q;
    assign es_fwd_blk_bus = {es_valid_q & es_bus_q.gr_we, blk, es_bus_q.dest, es_result};

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed self-checking bench for exe_stage
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic         clk;
    logic         resetn;
    logic         ms_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [160:0] ds_to_es_bus;
    logic         es_to_ms_valid;
    logic [75:0]  es_to_ms_bus;
    logic [64:0]  es_mul_res_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [38:0]  es_fwd_blk_bus;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] OP_ADD  = 12'h001;
    localparam logic [3:0]  DIV_W   = 4'b1000;
    localparam logic [3:0]  MOD_W   = 4'b0100;
    localparam logic [3:0]  DIV_WU  = 4'b0010;
    localparam logic [3:0]  MOD_WU  = 4'b0001;
    localparam logic [2:0]  MUL_W   = 3'b100;
    localparam logic [2:0]  MULH_W  = 3'b010;
    localparam logic [2:0]  MULH_WU = 3'b001;
    localparam logic [4:0]  LD_W    = 5'b00100;
    localparam logic [2:0]  ST_B    = 3'b100;
    localparam logic [2:0]  ST_H    = 3'b010;
    localparam logic [2:0]  ST_W    = 3'b001;

    exe_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ms_allowin      (ms_allowin),
        .es_allowin      (es_allowin),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .es_mul_res_bus  (es_mul_res_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .es_fwd_blk_bus  (es_fwd_blk_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ds_to_es_t mk(input logic [11:0] aop, input logic [3:0] dop,
                                     input logic [2:0] mop, input logic [4:0] lop,
                                     input logic [2:0] sop, input logic [31:0] s1,
                                     input logic [31:0] s2, input logic [31:0] rkd);
        ds_to_es_t b;
        b.alu_op    = aop;
        b.div_op    = dop;
        b.mul_op    = mop;
        b.load_op   = lop;
        b.store_op  = sop;
        b.gr_we     = (sop == 3'b000);
        b.dest      = 5'd7;
        b.src1      = s1;
        b.src2      = s2;
        b.rkd_value = rkd;
        b.pc        = 32'h1c00_0100;
        return b;
    endfunction

    // Present one instruction for a single clock and stop at the next falling edge
    task automatic issue(input ds_to_es_t b);
        ds_to_es_bus   = b;
        ds_to_es_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        #1;
    endtask

    // Issue a divide, count cycles in ES until its result is offered, check it
    task automatic run_div(input string tag, input ds_to_es_t b, input logic [31:0] exp_res);
        int cyc;
        issue(b);
        chk({tag, " blk at entry"}, es_fwd_blk_bus[37], 1'b1);
        chk({tag, " allowin at entry"}, es_allowin, 1'b0);
        cyc = 0;
        while (es_to_ms_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk({tag, " cycles to result"}, cyc, 33);
        chk({tag, " result"}, es_to_ms_bus[63:32], exp_res);
        chk({tag, " blk when done"}, es_fwd_blk_bus[37], 1'b0);
    endtask

    initial begin
        resetn         = 1'b0;
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset es_to_ms_valid", es_to_ms_valid, 1'b0);
        chk("reset sram_en", data_sram_en, 1'b0);
        chk("reset sram_we", data_sram_we, 4'h0);
        chk("reset fwd valid", es_fwd_blk_bus[38], 1'b0);
        chk("reset blk", es_fwd_blk_bus[37], 1'b0);
        chk("reset mul bus", es_mul_res_bus, 65'h0);
        chk("reset allowin", es_allowin, 1'b1);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // add 5 + 7
        issue(mk(OP_ADD, 4'h0, 3'h0, 5'h0, 3'h0, 32'd5, 32'd7, 32'd0));
        chk("add valid", es_to_ms_valid, 1'b1);
        chk("add result", es_to_ms_bus[63:32], 32'd12);
        chk("add fwd bus", es_fwd_blk_bus, {1'b1, 1'b0, 5'd7, 32'd12});
        chk("add sram_en", data_sram_en, 1'b0);
        chk("add res_from_mul", es_to_ms_bus[75], 1'b0);

        // st.b to 0x1003
        issue(mk(OP_ADD, 4'h0, 3'h0, 5'h0, ST_B, 32'h1000, 32'h3, 32'h0000_00AB));
        chk("st.b en", data_sram_en, 1'b1);
        chk("st.b we", data_sram_we, 4'b1000);
        chk("st.b wdata", data_sram_wdata, 32'hABAB_ABAB);
        chk("st.b addr", data_sram_addr, 32'h0000_1003);
        chk("st.b fwd valid", es_fwd_blk_bus[38], 1'b0);

        // st.h to 0x1002
        issue(mk(OP_ADD, 4'h0, 3'h0, 5'h0, ST_H, 32'h1000, 32'h2, 32'h0000_1234));
        chk("st.h we", data_sram_we, 4'b1100);
        chk("st.h wdata", data_sram_wdata, 32'h1234_1234);

        // st.w stalled by mem_stage, then released
        issue(mk(OP_ADD, 4'h0, 3'h0, 5'h0, ST_W, 32'h1000, 32'h0, 32'hDEAD_BEEF));
        ms_allowin = 1'b0;
        #1;
        chk("st.w stalled en", data_sram_en, 1'b0);
        chk("st.w stalled we", data_sram_we, 4'b0000);
        chk("st.w stalled allowin", es_allowin, 1'b0);
        ms_allowin = 1'b1;
        #1;
        chk("st.w en", data_sram_en, 1'b1);
        chk("st.w we", data_sram_we, 4'b1111);
        chk("st.w wdata", data_sram_wdata, 32'hDEAD_BEEF);

        // ld.w from 0x2004
        issue(mk(OP_ADD, 4'h0, 3'h0, LD_W, 3'h0, 32'h2000, 32'h4, 32'h0));
        chk("ld.w en", data_sram_en, 1'b1);
        chk("ld.w we", data_sram_we, 4'b0000);
        chk("ld.w addr", data_sram_addr, 32'h0000_2004);
        chk("ld.w blk", es_fwd_blk_bus[37], 1'b1);
        chk("ld.w load_op", es_to_ms_bus[74:70], LD_W);

        // multiplies
        issue(mk(12'h0, 4'h0, MULH_W, 5'h0, 3'h0, 32'hFFFF_FFFF, 32'd2, 32'h0));
        chk("mulh.w blk", es_fwd_blk_bus[37], 1'b1);
        chk("mulh.w res_from_mul", es_to_ms_bus[75], 1'b1);
        @(negedge clk);
        #1;
        chk("mulh.w product", es_mul_res_bus, 65'h1_FFFF_FFFF_FFFF_FFFE);
        chk("empty after mul", es_to_ms_valid, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("mul bus holds", es_mul_res_bus, 65'h1_FFFF_FFFF_FFFF_FFFE);

        issue(mk(12'h0, 4'h0, MULH_WU, 5'h0, 3'h0, 32'hFFFF_FFFF, 32'd2, 32'h0));
        @(negedge clk);
        #1;
        chk("mulh.wu product", es_mul_res_bus, 65'h1_0000_0001_FFFF_FFFE);

        issue(mk(12'h0, 4'h0, MUL_W, 5'h0, 3'h0, 32'd3, 32'hFFFF_FFFC, 32'h0));
        @(negedge clk);
        #1;
        chk("mul.w product", es_mul_res_bus, 65'h0_FFFF_FFFF_FFFF_FFF4);

        // divides, issued back to back
        run_div("div.w 100/-7", mk(12'h0, DIV_W, 3'h0, 5'h0, 3'h0, 32'd100, 32'hFFFF_FFF9, 32'h0), 32'hFFFF_FFF2);
        run_div("mod.w 100/-7", mk(12'h0, MOD_W, 3'h0, 5'h0, 3'h0, 32'd100, 32'hFFFF_FFF9, 32'h0), 32'd2);
        run_div("div.wu by 0", mk(12'h0, DIV_WU, 3'h0, 5'h0, 3'h0, 32'h8000_0000, 32'h0, 32'h0), 32'hFFFF_FFFF);
        run_div("mod.wu by 0", mk(12'h0, MOD_WU, 3'h0, 5'h0, 3'h0, 32'h8000_0000, 32'h0, 32'h0), 32'h8000_0000);
        run_div("div.w min/-1", mk(12'h0, DIV_W, 3'h0, 5'h0, 3'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0), 32'h8000_0000);

        // mem_stage stalls the finished divide for 5 cycles
        ms_allowin = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("hold valid", es_to_ms_valid, 1'b1);
            chk("hold result", es_to_ms_bus[63:32], 32'h8000_0000);
            chk("hold allowin", es_allowin, 1'b0);
            chk("hold sram_en", data_sram_en, 1'b0);
            @(negedge clk);
            #1;
        end
        ms_allowin = 1'b1;

        run_div("mod.w min/-1", mk(12'h0, MOD_W, 3'h0, 5'h0, 3'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0), 32'h0);
        @(negedge clk);
        #1;
        chk("empty after div", es_to_ms_valid, 1'b0);

        // reset while the divider is at count 10
        issue(mk(12'h0, DIV_W, 3'h0, 5'h0, 3'h0, 32'd100, 32'd7, 32'h0));
        repeat (11) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid-div reset valid", es_to_ms_valid, 1'b0);
        chk("mid-div reset blk", es_fwd_blk_bus[37], 1'b0);
        chk("mid-div reset fwd valid", es_fwd_blk_bus[38], 1'b0);
        chk("mid-div reset allowin", es_allowin, 1'b1);
        chk("mid-div reset mul bus", es_mul_res_bus, 65'h0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        run_div("div.w 9/3 after reset", mk(12'h0, DIV_W, 3'h0, 5'h0, 3'h0, 32'd9, 32'd3, 32'h0), 32'd3);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
